// File: rtl/brick_wall.sv
// brick_wall: ROWS x COLS brick field for the brick-smasher playfield.
// Holds the alive state of every brick and renders alive bricks per pixel.
// Once per frame it scans the bricks against the latched ball box, one brick
// per cycle, and clears at most one struck brick (lowest index wins).
module brick_wall #(
  parameter int          ROWS          = 4,
  parameter int          COLS          = 8,
  parameter int          WALL_LEFT     = 32,
  parameter int          WALL_TOP      = 48,
  parameter int          BRICK_W       = 64,
  parameter int          BRICK_H       = 16,
  parameter int          GAP           = 8,
  parameter int          BALL_SIZE     = 8,
  parameter logic [4:0]  BRICK_COLOR_r = 5'b00110,
  parameter logic [5:0]  BRICK_COLOR_g = 6'b100011,
  parameter logic [4:0]  BRICK_COLOR_b = 5'b10011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic        frame_tick,
  input  logic        restart,
  output logic        brick_on,
  output logic [4:0]  brick_rgb_r,
  output logic [5:0]  brick_rgb_g,
  output logic [4:0]  brick_rgb_b,
  output logic        hit,
  output logic        hit_dir,
  output logic [15:0] score,
  output logic [7:0]  bricks_left,
  output logic        wall_clear,
  output logic        busy
);

  localparam int         NB    = ROWS * COLS;
  localparam int         IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [7:0] NB8   = 8'(NB);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  // Left edge of brick k (row-major numbering).
  function automatic logic [11:0] brick_left(input int k);
    return 12'(WALL_LEFT + (k % COLS) * (BRICK_W + GAP));
  endfunction

  // Top edge of brick k (row-major numbering).
  function automatic logic [11:0] brick_top(input int k);
    return 12'(WALL_TOP + (k / COLS) * (BRICK_H + GAP));
  endfunction

  // Score counter increment that sticks at full scale.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NB-1:0]     r_alive;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_row;
  logic [7:0]        r_col;
  logic [11:0]       r_bx;
  logic [11:0]       r_by;
  logic              r_hit;
  logic              r_hit_dir;
  logic [15:0]       r_score;
  logic [7:0]        r_left;
  logic              r_clear;

  logic [11:0] w_px, w_py;
  logic        w_on;
  logic [11:0] w_left, w_right, w_top, w_bot;
  logic [11:0] w_bx_r, w_by_b, w_cx;
  logic        w_overlap, w_last, w_dir, w_hit_now;

  assign w_px = {1'b0, pix_x};
  assign w_py = {1'b0, pix_y};

  // Pixel renderer: pixel is lit when it lies inside any alive brick.
  always_comb begin
    w_on = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (r_alive[k] &&
          (w_px >= brick_left(k)) && (w_px <= brick_left(k) + 12'(BRICK_W - 1)) &&
          (w_py >= brick_top(k))  && (w_py <= brick_top(k)  + 12'(BRICK_H - 1)))
        w_on = 1'b1;
    end
  end

  // Geometry of the brick under examination; row/col counters avoid a divider.
  assign w_left    = 12'(WALL_LEFT + int'(r_col) * (BRICK_W + GAP));
  assign w_right   = w_left + 12'(BRICK_W - 1);
  assign w_top     = 12'(WALL_TOP + int'(r_row) * (BRICK_H + GAP));
  assign w_bot     = w_top + 12'(BRICK_H - 1);
  assign w_bx_r    = r_bx + 12'(BALL_SIZE - 1);
  assign w_by_b    = r_by + 12'(BALL_SIZE - 1);
  assign w_cx      = r_bx + 12'(BALL_SIZE / 2);
  assign w_overlap = r_alive[r_idx] &&
                     (r_bx <= w_right) && (w_left <= w_bx_r) &&
                     (r_by <= w_bot)   && (w_top  <= w_by_b);
  assign w_last    = (r_idx == IDX_W'(NB - 1));
  // Ball centre inside the brick's x-span means it came from above/below.
  assign w_dir     = !((w_left <= w_cx) && (w_cx <= w_right));

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Scan FSM next state; restart aborts a scan without a hit.
  always_comb begin
    w_state_nxt = r_state;
    w_hit_now   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_tick && !restart) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        if (restart) begin
          w_state_nxt = S_IDLE;
        end else if (w_overlap) begin
          w_hit_now   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ball latch and brick index walk; pure datapath, so no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && frame_tick) begin
      r_bx  <= {1'b0, ball_x};
      r_by  <= {1'b0, ball_y};
      r_idx <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (r_state == S_SCAN) begin
      r_idx <= r_idx + 1'b1;
      if (r_col == 8'(COLS - 1)) begin
        r_col <= '0;
        r_row <= r_row + 8'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  // Brick alive state, hit pulse, score and remaining-brick bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alive   <= '1;
      r_hit     <= 1'b0;
      r_hit_dir <= 1'b0;
      r_score   <= '0;
      r_left    <= NB8;
      r_clear   <= 1'b0;
    end else begin
      r_hit <= w_hit_now;
      if (restart) begin
        r_alive <= '1;
        r_left  <= NB8;
        r_clear <= 1'b0;
      end else if (w_hit_now) begin
        r_alive[r_idx] <= 1'b0;
        r_score        <= sat_inc(r_score);
        r_left         <= r_left - 8'd1;
        r_clear        <= (r_left == 8'd1);
        r_hit_dir      <= w_dir;
      end
    end
  end

  assign brick_on    = w_on;
  assign brick_rgb_r = BRICK_COLOR_r;
  assign brick_rgb_g = BRICK_COLOR_g;
  assign brick_rgb_b = BRICK_COLOR_b;
  assign hit         = r_hit;
  assign hit_dir     = r_hit_dir;
  assign score       = r_score;
  assign bricks_left = r_left;
  assign wall_clear  = r_clear;
  assign busy        = (r_state == S_SCAN);

endmodule

// File: tb/tb_brick_wall.sv
// Bench for brick_wall: two instances (default 4x8 wall, and a 1x2 wall with
// a 12-pixel ball). Stimulus pushes expected scan outcomes into a per-instance
// queue; a negedge monitor pops and compares whenever a scan ends.
module tb_brick_wall;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst        [2];
  logic [10:0] pix_x      [2];
  logic [10:0] pix_y      [2];
  logic [10:0] ball_x     [2];
  logic [10:0] ball_y     [2];
  logic        frame_tick [2];
  logic        restart    [2];
  logic        brick_on   [2];
  logic [4:0]  rgb_r      [2];
  logic [5:0]  rgb_g      [2];
  logic [4:0]  rgb_b      [2];
  logic        hit        [2];
  logic        hit_dir    [2];
  logic [15:0] score      [2];
  logic [7:0]  left       [2];
  logic        clear      [2];
  logic        busy       [2];

  brick_wall u_a (
    .clk(clk), .reset(rst[0]), .pix_x(pix_x[0]), .pix_y(pix_y[0]),
    .ball_x(ball_x[0]), .ball_y(ball_y[0]), .frame_tick(frame_tick[0]),
    .restart(restart[0]), .brick_on(brick_on[0]), .brick_rgb_r(rgb_r[0]),
    .brick_rgb_g(rgb_g[0]), .brick_rgb_b(rgb_b[0]), .hit(hit[0]),
    .hit_dir(hit_dir[0]), .score(score[0]), .bricks_left(left[0]),
    .wall_clear(clear[0]), .busy(busy[0])
  );

  brick_wall #(.ROWS(1), .COLS(2), .BALL_SIZE(12)) u_b (
    .clk(clk), .reset(rst[1]), .pix_x(pix_x[1]), .pix_y(pix_y[1]),
    .ball_x(ball_x[1]), .ball_y(ball_y[1]), .frame_tick(frame_tick[1]),
    .restart(restart[1]), .brick_on(brick_on[1]), .brick_rgb_r(rgb_r[1]),
    .brick_rgb_g(rgb_g[1]), .brick_rgb_b(rgb_b[1]), .hit(hit[1]),
    .hit_dir(hit_dir[1]), .score(score[1]), .bricks_left(left[1]),
    .wall_clear(clear[1]), .busy(busy[1])
  );

  // Reference model: geometry constants of the playfield and per-instance state.
  localparam int WL = 32, WT = 48, BW = 64, BH = 16, GP = 8;
  int  rows [2] = '{4, 1};
  int  cols [2] = '{8, 2};
  int  bsz  [2] = '{8, 12};
  bit  m_alive [2][32];
  int  m_score [2];
  bit  m_dir   [2];

  typedef struct {
    int cyc;
    bit hit;
    bit dir;
    int score;
    int left;
    bit clear;
  } exp_t;
  exp_t q [2][$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit prev_busy [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_left(input int d);
    int n = 0;
    for (int k = 0; k < rows[d] * cols[d]; k++) if (m_alive[d][k]) n++;
    return n;
  endfunction

  function automatic int m_on(input int d, input int px, input int py);
    for (int k = 0; k < rows[d] * cols[d]; k++) begin
      int l = WL + (k % cols[d]) * (BW + GP);
      int t = WT + (k / cols[d]) * (BH + GP);
      if (m_alive[d][k] && px >= l && px <= l + BW - 1 && py >= t && py <= t + BH - 1)
        return 1;
    end
    return 0;
  endfunction

  task automatic m_refill(input int d);
    for (int k = 0; k < 32; k++) m_alive[d][k] = 1'b1;
  endtask

  // Monitor: every falling edge of busy must match the oldest expected outcome.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (prev_busy[d] && !busy[d]) begin
          chk($sformatf("dut%0d_pending", d), q[d].size(), 1);
          if (q[d].size() > 0) begin
            exp_t e;
            e = q[d].pop_front();
            chk($sformatf("dut%0d_end_cycle", d), cyc, e.cyc);
            chk($sformatf("dut%0d_hit", d), int'(hit[d]), int'(e.hit));
            chk($sformatf("dut%0d_hit_dir", d), int'(hit_dir[d]), int'(e.dir));
            chk($sformatf("dut%0d_score", d), int'(score[d]), e.score);
            chk($sformatf("dut%0d_bricks_left", d), int'(left[d]), e.left);
            chk($sformatf("dut%0d_wall_clear", d), int'(clear[d]), int'(e.clear));
          end
        end else begin
          chk($sformatf("dut%0d_no_stray_hit", d), int'(hit[d]), 0);
        end
        prev_busy[d] = busy[d];
      end
    end
  end

  // mode 0: normal scan; 1: restart at T+3; 2: reset asserted at T+5.
  task automatic tick(input int d, input int bx, input int by, input int mode);
    exp_t e;
    int   n, k0, found;
    n = rows[d] * cols[d];
    @(posedge clk); #1;
    k0 = cyc;
    ball_x[d] = 11'(bx);
    ball_y[d] = 11'(by);
    frame_tick[d] = 1'b1;
    if (mode == 0) begin
      found = -1;
      for (int k = 0; k < n && found < 0; k++) begin
        int l = WL + (k % cols[d]) * (BW + GP);
        int t = WT + (k / cols[d]) * (BH + GP);
        if (m_alive[d][k] && bx <= l + BW - 1 && l <= bx + bsz[d] - 1 &&
            by <= t + BH - 1 && t <= by + bsz[d] - 1) begin
          int cx = bx + bsz[d] / 2;
          found = k;
          m_alive[d][k] = 1'b0;
          if (m_score[d] < 65535) m_score[d]++;
          m_dir[d] = !(cx >= l && cx <= l + BW - 1);
        end
      end
      e.hit = (found >= 0);
      e.cyc = (found >= 0) ? k0 + 2 + found : k0 + 1 + n;
    end else if (mode == 1) begin
      m_refill(d);
      e.hit = 1'b0;
      e.cyc = k0 + 4;
    end else begin
      m_refill(d);
      m_score[d] = 0;
      m_dir[d]   = 1'b0;
      e.hit = 1'b0;
      e.cyc = k0 + 6;
    end
    e.dir   = m_dir[d];
    e.score = m_score[d];
    e.left  = m_left(d);
    e.clear = (e.left == 0);
    q[d].push_back(e);
    @(posedge clk); #1;
    frame_tick[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("dut%0d_busy_rise", d), int'(busy[d]), 1);
    if (mode == 1) begin
      repeat (2) @(posedge clk);
      #1 restart[d] = 1'b1;
      @(posedge clk); #1 restart[d] = 1'b0;
    end else if (mode == 2) begin
      repeat (4) @(posedge clk);
      #1 rst[d] = 1'b1;
      @(posedge clk); #1 rst[d] = 1'b0;
    end
    for (int i = 0; i < 200 && q[d].size() != 0; i++) @(negedge clk);
    chk($sformatf("dut%0d_scan_completed", d), q[d].size(), 0);
    q[d].delete();
  endtask

  task automatic do_restart(input int d);
    @(posedge clk); #1 restart[d] = 1'b1;
    m_refill(d);
    @(posedge clk); #1 restart[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("dut%0d_restart_left", d), int'(left[d]), m_left(d));
    chk($sformatf("dut%0d_restart_clear", d), int'(clear[d]), 0);
    chk($sformatf("dut%0d_restart_score", d), int'(score[d]), m_score[d]);
  endtask

  task automatic pix(input int d, input int px, input int py, input int exp);
    @(posedge clk); #1;
    pix_x[d] = 11'(px);
    pix_y[d] = 11'(py);
    @(negedge clk);
    chk($sformatf("dut%0d_brick_on(%0d,%0d)", d, px, py), int'(brick_on[d]), exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; pix_x[d] = '0; pix_y[d] = '0; ball_x[d] = '0; ball_y[d] = '0;
      frame_tick[d] = 1'b0; restart[d] = 1'b0;
      m_refill(d); m_score[d] = 0; m_dir[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("a_reset_left", int'(left[0]), 32);
    chk("b_reset_left", int'(left[1]), 2);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d_reset_score", d), int'(score[d]), 0);
      chk($sformatf("dut%0d_reset_clear", d), int'(clear[d]), 0);
      chk($sformatf("dut%0d_reset_busy", d), int'(busy[d]), 0);
      chk($sformatf("dut%0d_reset_hit", d), int'(hit[d]), 0);
      chk($sformatf("dut%0d_reset_hit_dir", d), int'(hit_dir[d]), 0);
      prev_busy[d] = busy[d];
    end
    chk("rgb_r", int'(rgb_r[0]), 6);
    chk("rgb_g", int'(rgb_g[0]), 35);
    chk("rgb_b", int'(rgb_b[0]), 19);
    mon_en = 1'b1;

    // Default wall: rendering corners, miss, hit from above, repeat miss.
    pix(0, 32, 48, 1);
    pix(0, 95, 63, 1);
    pix(0, 96, 48, 0);
    tick(0, 60, 40, 0);
    tick(0, 60, 42, 0);
    pix(0, 32, 48, 0);
    tick(0, 60, 42, 0);
    // Side hit on brick 0 after refilling.
    do_restart(0);
    tick(0, 25, 52, 0);
    chk("a_side_hit_dir", int'(hit_dir[0]), 1);
    // Restart aborts an in-flight scan.
    tick(0, 0, 0, 1);
    pix(0, 32, 48, 1);

    // 1x2 wall with a 12-pixel ball straddling both bricks.
    pix(1, 32, 48, 1);
    pix(1, 104, 48, 1);
    tick(1, 94, 50, 0);
    tick(1, 94, 50, 0);
    chk("b_wall_clear", int'(clear[1]), 1);
    pix(1, 32, 48, 0);
    pix(1, 104, 48, 0);
    do_restart(1);
    chk("b_score_kept", int'(score[1]), 2);
    pix(1, 32, 48, 1);
    pix(1, 104, 48, 1);

    // Randomized frames against the model.
    for (int i = 0; i < 60; i++) begin
      int px, py;
      if (m_left(0) < 4) do_restart(0);
      tick(0, int'($urandom_range(0, 620)), int'($urandom_range(20, 160)), 0);
      px = int'($urandom_range(0, 640));
      py = int'($urandom_range(30, 160));
      pix(0, px, py, m_on(0, px, py));
    end

    // Reset in the middle of a scan.
    tick(0, 0, 0, 2);
    pix(0, 32, 48, 1);
    chk("a_post_reset_left", int'(left[0]), 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
